id_scoreboard: RTL and testbench

//  Parametrised hazard and forwarding tracker for the decode stage. It replaces the

---
 rtl/id_scoreboard_if.sv | 33 +++
 rtl/id_scoreboard.sv | 91 +++++++++
 tb/tb_id_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// Decode-stage hazard/forwarding bundle between the ID stage driver and id_scoreboard.
interface id_scoreboard_if #(
  parameter int RADDR_WIDTH = 5,
  parameter int DEPTH       = 2,
  parameter int LAT_W       = 2,
  parameter int CNT_W       = 32
);
  logic                   id_valid_i;
  logic [RADDR_WIDTH-1:0] rs1_i;
  logic                   rs1_re_i;
  logic [RADDR_WIDTH-1:0] rs2_i;
  logic                   rs2_re_i;
  logic [RADDR_WIDTH-1:0] rd_i;
  logic                   rd_we_i;
  logic [LAT_W-1:0]       lat_i;
  logic                   flush_i;
  logic                   hold_i;
  logic                   stallreq_o;
  logic                   issue_o;
  logic [DEPTH-1:0]       fwd1_sel_o;
  logic [DEPTH-1:0]       fwd2_sel_o;
  logic [CNT_W-1:0]       stall_cnt_o;

  modport master (
    output id_valid_i, rs1_i, rs1_re_i, rs2_i, rs2_re_i, rd_i, rd_we_i, lat_i, flush_i, hold_i,
    input  stallreq_o, issue_o, fwd1_sel_o, fwd2_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, rs1_i, rs1_re_i, rs2_i, rs2_re_i, rd_i, rd_we_i, lat_i, flush_i, hold_i,
    output stallreq_o, issue_o, fwd1_sel_o, fwd2_sel_o, stall_cnt_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// Tracks in-flight producers after ID (slot 0 = EXE) and derives stall requests,
// one-hot bypass selects and a saturating stall-cycle counter.
module id_scoreboard #(
  parameter int RADDR_WIDTH = 5,
  parameter int DEPTH       = 2,
  parameter int LAT_W       = 2,
  parameter int CNT_W       = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_scoreboard_if.slave sb_if
);

  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [RADDR_WIDTH-1:0] rd_q  [DEPTH];
  logic [RADDR_WIDTH-1:0] rd_d  [DEPTH];
  logic [LAT_W-1:0]       cnt_q [DEPTH];
  logic [LAT_W-1:0]       cnt_d [DEPTH];
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] fwd1_sel, fwd2_sel;
  logic             haz1, haz2, stallreq, issue;

  // Scan oldest to youngest so the youngest matching slot overrides older ones.
  always_comb begin
    fwd1_sel = '0;
    fwd2_sel = '0;
    haz1     = 1'b0;
    haz2     = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_if.rs1_re_i && (sb_if.rs1_i != '0) && vld_q[k] && (rd_q[k] == sb_if.rs1_i)) begin
        fwd1_sel    = '0;
        haz1        = (cnt_q[k] != '0);
        fwd1_sel[k] = (cnt_q[k] == '0);
      end
      if (sb_if.rs2_re_i && (sb_if.rs2_i != '0) && vld_q[k] && (rd_q[k] == sb_if.rs2_i)) begin
        fwd2_sel    = '0;
        haz2        = (cnt_q[k] != '0);
        fwd2_sel[k] = (cnt_q[k] == '0);
      end
    end
    stallreq = sb_if.id_valid_i & ~sb_if.flush_i & (haz1 | haz2);
    issue    = sb_if.id_valid_i & ~sb_if.flush_i & ~stallreq & ~sb_if.hold_i;
  end

  // Slot 0 takes the issuing instruction (or a bubble); older slots age by one.
  always_comb begin
    vld_d = '0;
    rd_d  = '{default: '0};
    cnt_d = '{default: '0};
    vld_d[0] = issue & sb_if.rd_we_i & (sb_if.rd_i != '0);
    rd_d[0]  = sb_if.rd_i;
    cnt_d[0] = sb_if.lat_i;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      cnt_d[k] = (cnt_q[k-1] != '0) ? cnt_q[k-1] - LAT_W'(1) : '0;
    end
    stall_cnt_d = (stallreq && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q       <= '0;
      rd_q        <= '{default: '0};
      cnt_q       <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (!sb_if.hold_i) begin
        vld_q <= vld_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end
  end

  // A producer slower than the tracked depth would drop out before it is forwardable.
  always_ff @(posedge clk_i) begin
    if (!rst_i && issue && sb_if.rd_we_i && (sb_if.rd_i != '0)) begin
      assert (32'(sb_if.lat_i) <= DEPTH - 1);
    end
  end

  assign sb_if.stallreq_o  = stallreq;
  assign sb_if.issue_o     = issue;
  assign sb_if.fwd1_sel_o  = fwd1_sel;
  assign sb_if.fwd2_sel_o  = fwd2_sel;
  assign sb_if.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Scenario bench for id_scoreboard: per-cycle expectations are queued as stimulus is
// applied and popped against the sampled outputs half a cycle later.
module tb_id_scoreboard;

  typedef struct packed {
    logic        v;
    logic [4:0]  r1;
    logic        e1;
    logic [4:0]  r2;
    logic        e2;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  lat;
    logic        fl;
    logic        hd;
    logic        rst;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] cnt;
  } obs_t;

  logic clk;
  logic rst;
  obs_t exp_q[$];
  int   checks;
  int   failures;

  id_scoreboard_if #(.RADDR_WIDTH(5), .DEPTH(2), .LAT_W(2), .CNT_W(32)) bus ();

  id_scoreboard #(.RADDR_WIDTH(5), .DEPTH(2), .LAT_W(2), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input int v, input int r1, input int e1, input int r2, input int e2,
                               input int rd, input int we, input int lat, input int fl,
                               input int hd, input int rs = 0);
    stim_t s;
    s.v   = 1'(v);
    s.r1  = 5'(r1);
    s.e1  = 1'(e1);
    s.r2  = 5'(r2);
    s.e2  = 1'(e2);
    s.rd  = 5'(rd);
    s.we  = 1'(we);
    s.lat = 2'(lat);
    s.fl  = 1'(fl);
    s.hd  = 1'(hd);
    s.rst = 1'(rs);
    return s;
  endfunction

  function automatic obs_t ex(input int stall, input int issue, input int f1, input int f2,
                              input int cnt);
    obs_t o;
    o.stall = 1'(stall);
    o.issue = 1'(issue);
    o.f1    = 2'(f1);
    o.f2    = 2'(f2);
    o.cnt   = 32'(cnt);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.stall = bus.stallreq_o;
    o.issue = bus.issue_o;
    o.f1    = bus.fwd1_sel_o;
    o.f2    = bus.fwd2_sel_o;
    o.cnt   = bus.stall_cnt_o;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid_i = s.v;
    bus.rs1_i      = s.r1;
    bus.rs1_re_i   = s.e1;
    bus.rs2_i      = s.r2;
    bus.rs2_re_i   = s.e2;
    bus.rd_i       = s.rd;
    bus.rd_we_i    = s.we;
    bus.lat_i      = s.lat;
    bus.flush_i    = s.fl;
    bus.hold_i     = s.hd;
    rst            = s.rst;
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s[3];
    obs_t  x[3];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 1); x[1] = ex(0, 0, 0, 0, 0);
    s[2] = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0); x[2] = ex(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_chain();
    stim_t s[3];
    obs_t  x[3];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); x[1] = ex(0, 1, 1, 1, 0);
    s[2] = mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0); x[2] = ex(0, 1, 2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL alu_chain[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    stim_t s[4];
    obs_t  x[4];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0); x[1] = ex(1, 0, 0, 0, 0);
    s[2] = mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0); x[2] = ex(0, 1, 2, 2, 1);
    s[3] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0); x[3] = ex(0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL load_use[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_youngest();
    stim_t s[6];
    obs_t  x[6];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);  x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);  x[1] = ex(0, 1, 0, 0, 0);
    s[2] = mk(1, 5, 1, 0, 0, 9, 1, 0, 0, 0);  x[2] = ex(0, 1, 1, 0, 0);
    // A load to x5 younger than a ready ALU x5 must still stall.
    s[3] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);  x[3] = ex(0, 1, 0, 0, 0);
    s[4] = mk(1, 5, 1, 0, 0, 10, 1, 0, 0, 0); x[4] = ex(1, 0, 0, 0, 0);
    s[5] = mk(1, 5, 1, 0, 0, 10, 1, 0, 0, 0); x[5] = ex(0, 1, 2, 0, 1);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL youngest[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_x0_nowrite();
    stim_t s[6];
    obs_t  x[6];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 0); x[1] = ex(0, 1, 0, 0, 0);
    s[2] = mk(1, 0, 0, 0, 0, 4, 0, 0, 0, 0); x[2] = ex(0, 1, 0, 0, 0);
    s[3] = mk(1, 4, 1, 1, 1, 0, 0, 0, 0, 0); x[3] = ex(0, 1, 0, 2, 0);
    s[4] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); x[4] = ex(0, 1, 0, 0, 0);
    s[5] = mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 0); x[5] = ex(0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL x0_nowrite[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    stim_t s[3];
    obs_t  x[3];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 7, 1, 0, 0, 7, 1, 1, 1, 0); x[1] = ex(0, 0, 0, 0, 0);
    s[2] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); x[2] = ex(0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL flush[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_reset();
    stim_t s[10];
    obs_t  x[10];
    obs_t  got, e;
    do_reset();
    s[0] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);    x[0] = ex(0, 1, 0, 0, 0);
    s[1] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);    x[1] = ex(1, 0, 0, 0, 0);
    s[2] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);    x[2] = ex(1, 0, 0, 0, 1);
    s[3] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);    x[3] = ex(1, 0, 0, 0, 2);
    s[4] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);    x[4] = ex(1, 0, 0, 0, 3);
    s[5] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);    x[5] = ex(0, 1, 2, 0, 4);
    s[6] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);    x[6] = ex(0, 1, 0, 0, 4);
    s[7] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);    x[7] = ex(1, 0, 0, 0, 4);
    s[8] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 1); x[8] = ex(1, 0, 0, 0, 5);
    s[9] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);    x[9] = ex(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(s[i]);
      exp_q.push_back(x[i]);
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL hold_reset[%0d] got=%h expected=%h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_x0_nowrite();
    test_flush();
    test_hold_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
